// File: rtl/uart_transceiver.sv
// 8N1 UART receiver and transmitter on a single clock.
// RX strobes each good byte; TX streams frames while enabled.
module uart_transceiver #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int TX_GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  input  logic       tx_enable,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);

  localparam int RCW = $clog2(CLKS_PER_BIT);
  localparam int TMAX =
    (CLKS_PER_BIT > TX_GAP_CYCLES) ? CLKS_PER_BIT : TX_GAP_CYCLES;
  localparam int TCW = $clog2(TMAX);

  localparam logic [RCW-1:0] R_BIT_LAST  = RCW'(CLKS_PER_BIT - 1);
  localparam logic [RCW-1:0] R_HALF_LAST = RCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TCW-1:0] T_BIT_LAST  = TCW'(CLKS_PER_BIT - 1);
  localparam logic [TCW-1:0] T_GAP_LAST  = TCW'(TX_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP
  } tx_state_t;

  // RX path
  logic           r_rx_s1, r_rx_s2;
  logic           w_rx;
  rx_state_t      r_rx_state, w_rx_state_nxt;
  logic [RCW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]     r_rx_bit, w_rx_bit_nxt;
  logic [7:0]     r_rx_shift, w_rx_shift_nxt;
  logic [7:0]     r_rx_data, w_rx_data_nxt;
  logic           r_rx_done, w_rx_done_nxt;
  logic           r_rx_err, w_rx_err_nxt;

  assign w_rx = r_rx_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_done  <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_done  <= w_rx_done_nxt;
      r_rx_err   <= w_rx_err_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_done_nxt  = 1'b0;
    w_rx_err_nxt   = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (rx_enable && !w_rx) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == R_HALF_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == R_BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {w_rx, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == R_BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          if (w_rx) begin
            w_rx_data_nxt = r_rx_shift;
            w_rx_done_nxt = 1'b1;
          end else begin
            w_rx_err_nxt = 1'b1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_data      = r_rx_data;
  assign rx_done      = r_rx_done;
  assign rx_frame_err = r_rx_err;

  // TX path
  tx_state_t      r_tx_state, w_tx_state_nxt;
  logic [TCW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]     r_tx_bit, w_tx_bit_nxt;
  logic [7:0]     r_tx_shift, w_tx_shift_nxt;
  logic           r_tx, w_tx_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (tx_enable) begin
          w_tx_state_nxt = TX_START;
          w_tx_shift_nxt = tx_data;
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == T_BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == T_BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = {1'b1, r_tx_shift[7:1]};
          w_tx_bit_nxt   = r_tx_bit + 1'b1;
          if (r_tx_bit == 3'd7) w_tx_state_nxt = TX_STOP;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == T_BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt =
            (TX_GAP_CYCLES == 0) ? TX_IDLE : TX_GAP;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_GAP: begin
        if (r_tx_cnt == T_GAP_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    // Line level follows the state being entered so tx stays a flop
    unique case (w_tx_state_nxt)
      TX_START: w_tx_nxt = 1'b0;
      TX_DATA:  w_tx_nxt = w_tx_shift_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign tx      = r_tx;
  assign tx_done = (r_tx_state == TX_STOP) &&
                   (r_tx_cnt == T_BIT_LAST);

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver with CLKS_PER_BIT=16.
// Each scenario task drives stimulus and checks inline.
module tb_uart_transceiver;

  localparam int CPB = 16;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_enable = 1'b0;
  logic       tx_enable = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;
  logic       tx;
  logic       tx_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rx_done_cnt = 0;
  int rx_err_cnt = 0;
  int tx_done_cnt = 0;
  int rx_done_cyc = 0;

  uart_transceiver #(
    .CLKS_PER_BIT (CPB),
    .TX_GAP_CYCLES(GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_enable   (rx_enable),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_frame_err(rx_frame_err),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .tx          (tx),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      rx_done_cnt = rx_done_cnt + 1;
      rx_done_cyc = cyc;
    end
    if (rx_frame_err === 1'b1) rx_err_cnt = rx_err_cnt + 1;
    if (tx_done === 1'b1) tx_done_cnt = tx_done_cnt + 1;
  end

  task automatic send_rx(input logic [7:0] b, input logic stop,
                         output int t0);
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic get_tx(output logic [7:0] b, output logic ok);
    bit found = 0;
    ok = 1'b1;
    b = 8'h00;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      ok = 1'b0;
    end else begin
      repeat (CPB / 2) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_tx_done(output logic ok, output int t);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL reset_tx: got %b expected 1", tx);
    end
    tests++;
    if (rx_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_rx_done: got %b expected 0", rx_done);
    end
    tests++;
    if (tx_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_tx_done: got %b expected 0", tx_done);
    end
    tests++;
    if (rx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
    tests++;
    if (rx_frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err);
    end
    reset = 1'b1;
    repeat (50) @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL idle_tx: got %b expected 1", tx);
    end
    tests++;
    if (rx_done_cnt + rx_err_cnt + tx_done_cnt != 0) begin
      fails++;
      $display("FAIL idle_strobes: got %0d expected 0",
               rx_done_cnt + rx_err_cnt + tx_done_cnt);
    end
  endtask

  task automatic test_rx_byte(input logic [7:0] b);
    int t0;
    int c0 = rx_done_cnt;
    rx_enable = 1'b1;
    send_rx(b, 1'b1, t0);
    tests++;
    if (rx_done_cnt - c0 != 1) begin
      fails++;
      $display("FAIL rx_done_count %h: got %0d expected 1",
               b, rx_done_cnt - c0);
    end
    tests++;
    if (rx_data !== b) begin
      fails++;
      $display("FAIL rx_data: got %h expected %h", rx_data, b);
    end
    tests++;
    if (rx_done_cyc - t0 < 153 || rx_done_cyc - t0 > 155) begin
      fails++;
      $display("FAIL rx_latency %h: got %0d expected 153..155",
               b, rx_done_cyc - t0);
    end
  endtask

  task automatic test_rx_glitch_ferr();
    int t0;
    int c0 = rx_done_cnt;
    int e0 = rx_err_cnt;
    rx_enable = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    tests++;
    if (rx_done_cnt != c0 || rx_err_cnt != e0) begin
      fails++;
      $display("FAIL rx_glitch: got done %0d err %0d expected none",
               rx_done_cnt - c0, rx_err_cnt - e0);
    end
    send_rx(8'h3C, 1'b0, t0);
    tests++;
    if (rx_err_cnt - e0 != 1) begin
      fails++;
      $display("FAIL rx_frame_err: got %0d expected 1", rx_err_cnt - e0);
    end
    tests++;
    if (rx_done_cnt != c0) begin
      fails++;
      $display("FAIL rx_ferr_done: got %0d expected 0", rx_done_cnt - c0);
    end
    tests++;
    if (rx_data !== 8'hFF) begin
      fails++;
      $display("FAIL rx_ferr_data: got %h expected ff", rx_data);
    end
  endtask

  task automatic test_rx_gating();
    int t0;
    int c0 = rx_done_cnt;
    rx_enable = 1'b0;
    send_rx(8'h11, 1'b1, t0);
    tests++;
    if (rx_done_cnt != c0) begin
      fails++;
      $display("FAIL rx_gated: got %0d expected 0", rx_done_cnt - c0);
    end
  endtask

  task automatic test_rx_enable_drop();
    int t0;
    int c0 = rx_done_cnt;
    rx_enable = 1'b1;
    fork
      send_rx(8'h7E, 1'b1, t0);
      begin
        repeat (50) @(negedge clk);
        rx_enable = 1'b0;
      end
    join
    tests++;
    if (rx_done_cnt - c0 != 1) begin
      fails++;
      $display("FAIL rx_drop_done: got %0d expected 1", rx_done_cnt - c0);
    end
    tests++;
    if (rx_data !== 8'h7E) begin
      fails++;
      $display("FAIL rx_drop_data: got %h expected 7e", rx_data);
    end
  endtask

  task automatic test_tx_stream();
    logic [7:0] b1, b2;
    logic ok1, ok2, ok3, ok4;
    int t1, t2;
    int lows = 0;
    int c0 = tx_done_cnt;
    tx_data = 8'h55;
    tx_enable = 1'b1;
    fork
      begin
        get_tx(b1, ok1);
        get_tx(b2, ok2);
      end
      begin
        wait_tx_done(ok3, t1);
        tx_data = 8'h0F;
        wait_tx_done(ok4, t2);
        tx_enable = 1'b0;
      end
    join
    tests++;
    if (!ok1 || b1 !== 8'h55) begin
      fails++;
      $display("FAIL tx_byte1: got %h ok %b expected 55", b1, ok1);
    end
    tests++;
    if (!ok2 || b2 !== 8'h0F) begin
      fails++;
      $display("FAIL tx_byte2: got %h ok %b expected 0f", b2, ok2);
    end
    tests++;
    if (!ok3 || !ok4) begin
      fails++;
      $display("FAIL tx_done_seen: got %b%b expected 11", ok3, ok4);
    end
    tests++;
    if (t2 - t1 != 10 * CPB + GAP + 1) begin
      fails++;
      $display("FAIL tx_period: got %0d expected %0d",
               t2 - t1, 10 * CPB + GAP + 1);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    tests++;
    if (lows != 0) begin
      fails++;
      $display("FAIL tx_no_third: got %0d low cycles expected 0", lows);
    end
    tests++;
    if (tx_done_cnt - c0 != 2) begin
      fails++;
      $display("FAIL tx_done_count: got %0d expected 2", tx_done_cnt - c0);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b;
    logic ok;
    int c0;
    bit found = 0;
    tx_data = 8'hE7;
    tx_enable = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL tx_start_timeout: got none expected start bit");
    end
    repeat (CPB + 40) @(negedge clk);
    c0 = tx_done_cnt;
    reset = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_tx: got %b expected 1", tx);
    end
    tx_data = 8'h3A;
    repeat (20) @(negedge clk);
    tests++;
    if (tx !== 1'b1 || tx_done_cnt != c0) begin
      fails++;
      $display("FAIL reset_hold: got tx %b done %0d expected 1 0",
               tx, tx_done_cnt - c0);
    end
    reset = 1'b1;
    get_tx(b, ok);
    tx_enable = 1'b0;
    repeat (40) @(negedge clk);
    tests++;
    if (!ok || b !== 8'h3A) begin
      fails++;
      $display("FAIL tx_after_reset: got %h ok %b expected 3a", b, ok);
    end
    tests++;
    if (tx_done_cnt - c0 != 1) begin
      fails++;
      $display("FAIL tx_after_reset_done: got %0d expected 1",
               tx_done_cnt - c0);
    end
  endtask

  initial begin
    test_reset();
    test_rx_byte(8'hA5);
    test_rx_byte(8'h00);
    test_rx_byte(8'hFF);
    test_rx_glitch_ferr();
    test_rx_gating();
    test_rx_enable_drop();
    test_tx_stream();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
